ex_mem_pipe: RTL and testbench

EX/MEM pipeline register of the pipelined RV32 core, directly downstream of the ALU. Captures the ALU result and its flags (zero, overflow, carry, negative) with the EX-stage control bundle, resolves conditional branches and jumps from those flags, and issues a one-cycle redirect to fetch. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

---
 rtl/ex_mem_pipe.sv | 163 ++++++++++++++++
 tb/tb_ex_mem_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: captures ALU result/flags and controls, resolves branches/jumps, issues a one-cycle redirect.
// Optional branch performance counters are enabled with `define EX_MEM_PERF_CNT_EN.
module ex_mem_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            zero_i,
  input  logic            overflow_i,
  input  logic            carry_i,
  input  logic            negative_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            branch_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  input  logic [2:0]      funct3_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            reg_write_i,
  input  logic            mem_to_reg_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            reg_write_o,
  output logic            mem_to_reg_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]     br_count_o,
  output logic [31:0]     br_taken_o
`endif
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] store_q, store_d;
  logic [4:0]      rd_q, rd_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_to_reg_q, mem_to_reg_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            br_cond;
  logic            jump;
  logic            taken;
  logic [XLEN-1:0] link_addr;
  logic [XLEN-1:0] target;

  // Flags come from in1-in2; carry is NOT-borrow, so C=1 means in1 >= in2 unsigned.
  always_comb begin
    br_cond = 1'b0;
    case (funct3_i)
      3'b000:  br_cond = zero_i;
      3'b001:  br_cond = ~zero_i;
      3'b100:  br_cond = negative_i ^ overflow_i;
      3'b101:  br_cond = ~(negative_i ^ overflow_i);
      3'b110:  br_cond = ~carry_i;
      3'b111:  br_cond = carry_i;
      default: br_cond = 1'b0;
    endcase
  end

  assign jump      = jal_i | jalr_i;
  assign taken     = jump | (branch_i & br_cond);
  assign link_addr = pc_i + XLEN'(4);
  assign target    = jalr_i ? (alu_result_i & ~XLEN'(1)) : (pc_i + imm_i);

  always_comb begin
    valid_d       = valid_q;
    result_d      = result_q;
    store_d       = store_q;
    rd_d          = rd_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    reg_write_d   = reg_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      valid_d       = valid_i;
      result_d      = jump ? link_addr : alu_result_i;
      store_d       = rs2_data_i;
      rd_d          = rd_addr_i;
      mem_read_d    = mem_read_i;
      mem_write_d   = mem_write_i;
      reg_write_d   = reg_write_i;
      mem_to_reg_d  = mem_to_reg_i;
      redirect_d    = valid_i & taken;
      redirect_pc_d = target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= 1'b0;
      result_q      <= '0;
      store_q       <= '0;
      rd_q          <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      valid_q       <= valid_d;
      result_q      <= result_d;
      store_q       <= store_d;
      rd_q          <= rd_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      reg_write_q   <= reg_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign valid_o       = valid_q;
  assign result_o      = result_q;
  assign store_data_o  = store_q;
  assign rd_addr_o     = rd_q;
  assign mem_read_o    = mem_read_q & valid_q;
  assign mem_write_o   = mem_write_q & valid_q;
  assign reg_write_o   = reg_write_q & valid_q;
  assign mem_to_reg_o  = mem_to_reg_q & valid_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] br_count_q, br_taken_q;

  // Counts every offered valid branch, independent of stall and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_q <= '0;
      br_taken_q <= '0;
    end else if (valid_i && branch_i) begin
      br_count_q <= br_count_q + 32'd1;
      if (br_cond) br_taken_q <= br_taken_q + 32'd1;
    end
  end

  assign br_count_o = br_count_q;
  assign br_taken_o = br_taken_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: operand-level reference model compared every cycle, plus literal spot checks.
module tb_ex_mem_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, valid_i;
  logic [31:0] alu_result_i, rs2_data_i, pc_i, imm_i;
  logic        zero_i, overflow_i, carry_i, negative_i;
  logic [4:0]  rd_addr_i;
  logic        branch_i, jal_i, jalr_i;
  logic [2:0]  funct3_i;
  logic        mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i;
  logic        valid_o;
  logic [31:0] result_o, store_data_o, redirect_pc_o;
  logic [4:0]  rd_addr_o;
  logic        mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o, redirect_o;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] br_count_o, br_taken_o;
  int unsigned m_cnt, m_tkn;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state, derived from the operands rather than from the flags.
  logic        m_valid, m_mr, m_mw, m_rw, m_m2r, m_redir;
  logic [31:0] m_result, m_store, m_rpc;
  logic [4:0]  m_rd;
  logic [31:0] op_a, op_b;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .alu_result_i(alu_result_i), .zero_i(zero_i), .overflow_i(overflow_i),
    .carry_i(carry_i), .negative_i(negative_i), .rs2_data_i(rs2_data_i),
    .pc_i(pc_i), .imm_i(imm_i), .rd_addr_i(rd_addr_i), .branch_i(branch_i),
    .jal_i(jal_i), .jalr_i(jalr_i), .funct3_i(funct3_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
    .valid_o(valid_o), .result_o(result_o), .store_data_o(store_data_o),
    .rd_addr_o(rd_addr_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o)
`ifdef EX_MEM_PERF_CNT_EN
    , .br_count_o(br_count_o), .br_taken_o(br_taken_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {zero, overflow, carry, negative} of a-b as an ALU would report them.
  function automatic logic [3:0] sub_flags(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] d;
    s = {1'b0, a} + {1'b0, ~b} + 33'd1;
    d = s[31:0];
    return {d == 32'd0, (a[31] != b[31]) && (d[31] != a[31]), s[32], d[31]};
  endfunction

  function automatic logic cmp_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_m2r = 0; m_redir = 0;
    m_result = 0; m_store = 0; m_rpc = 0; m_rd = 0;
`ifdef EX_MEM_PERF_CNT_EN
    m_cnt = 0; m_tkn = 0;
`endif
  endtask

  task automatic model_edge();
    logic tk;
    if (rst) begin
      model_reset();
      return;
    end
    tk = jal_i | jalr_i | (branch_i & cmp_taken(funct3_i, op_a, op_b));
`ifdef EX_MEM_PERF_CNT_EN
    if (valid_i && branch_i) begin
      m_cnt++;
      if (cmp_taken(funct3_i, op_a, op_b)) m_tkn++;
    end
`endif
    if (flush_i) begin
      m_valid = 0; m_redir = 0;
    end else if (stall_i) begin
      m_redir = 0;
    end else begin
      m_valid  = valid_i;
      m_result = (jal_i | jalr_i) ? pc_i + 32'd4 : alu_result_i;
      m_store  = rs2_data_i;
      m_rd     = rd_addr_i;
      m_mr = mem_read_i; m_mw = mem_write_i; m_rw = reg_write_i; m_m2r = mem_to_reg_i;
      m_redir  = valid_i & tk;
      m_rpc    = jalr_i ? {alu_result_i[31:1], 1'b0} : pc_i + imm_i;
    end
  endtask

  task automatic compare_all();
    chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
    chk("redirect_o", {31'd0, redirect_o}, {31'd0, m_redir});
    chk("mem_read_o", {31'd0, mem_read_o}, {31'd0, m_mr & m_valid});
    chk("mem_write_o", {31'd0, mem_write_o}, {31'd0, m_mw & m_valid});
    chk("reg_write_o", {31'd0, reg_write_o}, {31'd0, m_rw & m_valid});
    chk("mem_to_reg_o", {31'd0, mem_to_reg_o}, {31'd0, m_m2r & m_valid});
    if (m_valid) begin
      chk("result_o", result_o, m_result);
      chk("store_data_o", store_data_o, m_store);
      chk("rd_addr_o", {27'd0, rd_addr_o}, {27'd0, m_rd});
      chk("redirect_pc_o", redirect_pc_o, m_rpc);
    end
`ifdef EX_MEM_PERF_CNT_EN
    chk("br_count_o", br_count_o, m_cnt);
    chk("br_taken_o", br_taken_o, m_tkn);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_defaults();
    stall_i = 0; flush_i = 0; valid_i = 1;
    alu_result_i = 0; rs2_data_i = 0; pc_i = 0; imm_i = 0; rd_addr_i = 0;
    {zero_i, overflow_i, carry_i, negative_i} = 4'b0;
    branch_i = 0; jal_i = 0; jalr_i = 0; funct3_i = 0;
    mem_read_i = 0; mem_write_i = 0; reg_write_i = 0; mem_to_reg_i = 0;
    op_a = 0; op_b = 0;
  endtask

  task automatic do_alu(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [3:0] ctl);
    set_defaults();
    alu_result_i = alu; rs2_data_i = rs2; rd_addr_i = rd;
    {mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i} = ctl;
  endtask

  task automatic do_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm);
    set_defaults();
    branch_i = 1; funct3_i = f3; op_a = a; op_b = b;
    alu_result_i = a - b;
    {zero_i, overflow_i, carry_i, negative_i} = sub_flags(a, b);
    pc_i = pc; imm_i = imm; rs2_data_i = b;
  endtask

  task automatic do_jump(input logic is_jalr, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] alu);
    set_defaults();
    jal_i = ~is_jalr; jalr_i = is_jalr;
    pc_i = pc; imm_i = imm; alu_result_i = alu; rd_addr_i = 5'd1; reg_write_i = 1;
  endtask

  logic [31:0] pa[4];
  logic [31:0] pb[4];

  initial begin
    rst = 1;
    set_defaults();
    valid_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset result_o", result_o, 32'd0);
    chk("reset redirect_o", {31'd0, redirect_o}, 32'd0);
    chk("reset redirect_pc_o", redirect_pc_o, 32'd0);
    chk("reset reg_write_o", {31'd0, reg_write_o}, 32'd0);
    compare_all();
    rst = 0;

    do_alu(32'h1234, 32'hCAFE, 5'd3, 4'b0010);
    step();
    chk("first capture result", result_o, 32'h1234);

    do_br(3'b100, 32'd1, 32'd2, 32'h100, 32'h20);   // N=1 V=0
    step();
    chk("BLT taken redirect", {31'd0, redirect_o}, 32'd1);
    chk("BLT target", redirect_pc_o, 32'h120);
    do_br(3'b100, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h100, 32'h20);   // N=1 V=1
    step();
    chk("BLT N=V no redirect", {31'd0, redirect_o}, 32'd0);

    pa[0] = 32'd5;          pb[0] = 32'd5;
    pa[1] = 32'd3;          pb[1] = 32'hFFFF_FFFF;
    pa[2] = 32'hFFFF_FFFF;  pb[2] = 32'd3;
    pa[3] = 32'h8000_0000;  pb[3] = 32'd1;
    for (int i = 0; i < 4; i++) begin
      for (int f = 0; f < 8; f++) begin
        do_br(3'(f), pa[i], pb[i], 32'h1000 + 32'(i * 64), 32'hFFFF_FFF0 + 32'(f));
        step();
      end
    end

    do_jump(1'b1, 32'h200, 32'h0, 32'h305);
    step();
    chk("JALR link", result_o, 32'h204);
    chk("JALR target", redirect_pc_o, 32'h304);
    chk("JALR redirect", {31'd0, redirect_o}, 32'd1);
    do_jump(1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0);
    step();
    chk("JAL link wrap", result_o, 32'h0);
    chk("JAL target wrap", redirect_pc_o, 32'h4);

    do_br(3'b000, 32'h42, 32'h42, 32'h300, 32'h40);
    step();
    chk("BEQ redirect", {31'd0, redirect_o}, 32'd1);
    do_alu(32'hDEAD, 32'hBEEF, 5'd9, 4'b0100);
    stall_i = 1;
    for (int k = 0; k < 3; k++) step();
    chk("stall redirect dropped", {31'd0, redirect_o}, 32'd0);
    chk("stall target held", redirect_pc_o, 32'h340);
    chk("stall valid held", {31'd0, valid_o}, 32'd1);
    stall_i = 0;
    step();

    do_alu(32'h80, 32'h77, 5'd0, 4'b0100);
    step();
    flush_i = 1; stall_i = 1;
    step();
    chk("flush+stall valid_o", {31'd0, valid_o}, 32'd0);
    chk("flush+stall mem_write_o", {31'd0, mem_write_o}, 32'd0);

    do_alu(32'h99, 32'h11, 5'd4, 4'b0110);
    valid_i = 0;
    step();
    chk("bubble mem_write_o", {31'd0, mem_write_o}, 32'd0);
    chk("bubble reg_write_o", {31'd0, reg_write_o}, 32'd0);

    do_br(3'b001, 32'd1, 32'd2, 32'h500, 32'h10);
    step();
    stall_i = 1;
    rst = 1;
    #1;
    chk("async reset redirect_o", {31'd0, redirect_o}, 32'd0);
    chk("async reset valid_o", {31'd0, valid_o}, 32'd0);
    chk("async reset redirect_pc_o", redirect_pc_o, 32'd0);
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 0;
    do_alu(32'h55, 32'h66, 5'd7, 4'b1011);
    step();
    chk("post-reset capture", result_o, 32'h55);

`ifdef EX_MEM_PERF_CNT_EN
    rst = 1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    do_br(3'b000, 32'd5, 32'd5, 32'h0, 32'h8); step();   // taken
    do_br(3'b001, 32'd5, 32'd5, 32'h0, 32'h8); step();   // not taken
    do_br(3'b100, 32'd1, 32'd2, 32'h0, 32'h8); step();   // taken
    do_br(3'b111, 32'd1, 32'd2, 32'h0, 32'h8); step();   // not taken
    do_br(3'b110, 32'd1, 32'd2, 32'h0, 32'h8); flush_i = 1; step();   // taken, flushed
    chk("br_count_o total", br_count_o, 32'd5);
    chk("br_taken_o total", br_taken_o, 32'd3);
`endif

    set_defaults();
    valid_i = 0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
